// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / register-write bundle between the UART receiver side and uart_cmd_ctrl.
interface uart_cmd_ctrl_if #(
    parameter int WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] rx_data;
    logic                 rx_done;
    logic [5:0]           rx_bits;
    logic [7:0]           reg_addr;
    logic [31:0]          reg_wdata;
    logic                 reg_we;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_data, rx_done,
        input  rx_bits, reg_addr, reg_wdata, reg_we, frame_err, busy
    );

    modport slave (
        input  rx_data, rx_done,
        output rx_bits, reg_addr, reg_wdata, reg_we, frame_err, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command framer: A5, addr, payload (LSB first) -> one register write.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_cmd_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] CFG_ADDR = 8'hFF;
    localparam logic [1:0] LAST     = 2'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
`ifdef UART_CMD_CHECKSUM_EN
        CSUM,
`endif
        COMMIT
    } state_t;

    state_t        state, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [5:0]    bits_q;
    logic [7:0]    out_addr;
    logic [31:0]   out_data;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic [7:0] byte_in;
    logic       expired;
    logic       is_cfg;
    logic       cfg_ok;

    assign byte_in = bus.rx_data[7:0];
    assign expired = (tmo_q == TW'(TIMEOUT));
    assign is_cfg  = (addr_q == CFG_ADDR);
    assign cfg_ok  = (data_q[5:0] != 6'd0) && (data_q[5:0] <= 6'(WORD_SIZE));

    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tmo_d   = '0;
        err_d   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        // COMMIT lasts one cycle and treats any byte in it like IDLE does
        if (state == IDLE || state == COMMIT) begin
            state_d = (bus.rx_done && byte_in == SYNC) ? ADDR : IDLE;
        end else if (!bus.rx_done) begin
            if (expired) begin
                state_d = IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            unique case (state)
                ADDR: begin
                    addr_d  = byte_in;
                    data_d  = '0;
                    cnt_d   = '0;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d  = byte_in;
`endif
                    state_d = DATA;
                end
                DATA: begin
                    data_d[{cnt_q, 3'b000} +: 8] = byte_in;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (cnt_q == LAST) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = COMMIT;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                CSUM: begin
                    if (byte_in == csum_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            bits_q   <= 6'(WORD_SIZE);
            out_addr <= '0;
            out_data <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q <= csum_d;
`endif
            // write outputs load on COMMIT entry so they are valid with reg_we
            if (state_d == COMMIT && !is_cfg) begin
                out_addr <= addr_q;
                out_data <= data_d;
            end
            if (state == COMMIT && is_cfg && cfg_ok) begin
                bits_q <= data_q[5:0];
            end
        end
    end

    assign bus.rx_bits   = bits_q;
    assign bus.reg_addr  = out_addr;
    assign bus.reg_wdata = out_data;
    assign bus.reg_we    = (state == COMMIT) && !is_cfg;
    assign bus.frame_err = err_q || ((state == COMMIT) && is_cfg && !cfg_ok);
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus random frames
// against a frame-level reference model.
module tb_uart_cmd_ctrl;
    localparam int WS = 8;
    localparam int DB = 4;
    localparam int TO = 20;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [7:0]  exp_addr = 8'h00;
    logic [31:0] exp_data = 32'h0;
    logic [5:0]  exp_bits = 6'(WS);

    uart_cmd_ctrl_if #(.WORD_SIZE(WS)) bus ();

    uart_cmd_ctrl #(
        .WORD_SIZE(WS),
        .DATA_BYTES(DB),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_we"}, bus.reg_we, 0);
        chk({tag, "_err"}, bus.frame_err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_addr"}, bus.reg_addr, exp_addr);
        chk({tag, "_data"}, bus.reg_wdata, exp_data);
        chk({tag, "_bits"}, bus.rx_bits, exp_bits);
    endtask

    task automatic frame(input logic [7:0] a, input logic [31:0] d,
                         input bit bad, input bit rnd_gap, input bit chain);
        logic [7:0] q[$];
        logic [7:0] cs;
        bit ok, w, e;
        int g;
        q = {8'hA5, a};
        cs = a;
        for (int k = 0; k < DB; k++) begin
            q.push_back(d[8*k +: 8]);
            cs ^= d[8*k +: 8];
        end
        if (CSUM_ON) q.push_back(bad ? ~cs : cs);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0 && rnd_gap) begin
                g = ($urandom_range(0, 5) == 0) ? TO : $urandom_range(0, 2);
                idle(g);
            end
            send(q[i]);
            if (i < q.size() - 1) begin
                chk("mid_we", bus.reg_we, 0);
                chk("mid_err", bus.frame_err, 0);
                chk("mid_busy", bus.busy, 1);
                chk("mid_addr", bus.reg_addr, exp_addr);
                chk("mid_data", bus.reg_wdata, exp_data);
            end
        end
        ok = !(CSUM_ON && bad);
        w = ok && (a != 8'hFF);
        e = !ok || (a == 8'hFF && !(d[5:0] >= 6'd1 && d[5:0] <= 6'(WS)));
        if (w) begin
            exp_addr = a;
            exp_data = d;
        end
        chk("end_we", bus.reg_we, 32'(w));
        chk("end_err", bus.frame_err, 32'(e));
        chk("end_busy", bus.busy, 32'(ok));
        chk("end_addr", bus.reg_addr, exp_addr);
        chk("end_data", bus.reg_wdata, exp_data);
        if (ok && a == 8'hFF && !e) exp_bits = d[5:0];
        if (!chain) begin
            tick();
            check_quiet("post");
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [31:0] d;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_quiet("reset");

        send(8'h55);
        check_quiet("idle_junk");

        frame(8'h10, 32'h11223344, 1'b0, 1'b0, 1'b0);
        frame(8'h10, 32'h11223344, 1'b1, 1'b0, 1'b0);
        frame(8'hFF, 32'h00000007, 1'b0, 1'b0, 1'b0);
        frame(8'hFF, 32'h00000009, 1'b0, 1'b0, 1'b0);
        frame(8'hFF, 32'h00000000, 1'b0, 1'b0, 1'b0);
        frame(8'hFF, 32'h00000008, 1'b0, 1'b0, 1'b0);

        send(8'hA5);
        send(8'h10);
        idle(TO);
        chk("tmo_busy_hold", bus.busy, 1);
        chk("tmo_err_early", bus.frame_err, 0);
        tick();
        chk("tmo_err", bus.frame_err, 1);
        chk("tmo_busy", bus.busy, 0);
        chk("tmo_we", bus.reg_we, 0);
        tick();
        check_quiet("tmo_after");
        frame(8'h22, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);

        frame(8'h31, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);
        frame(8'h32, 32'h01020304, 1'b0, 1'b0, 1'b0);

        send(8'hA5);
        send(8'h10);
        send(8'h44);
        send(8'h33);
        send(8'h22);
        rst = 1'b1;
        send(8'h11);
        rst = 1'b0;
        exp_addr = 8'h00;
        exp_data = 32'h0;
        exp_bits = 6'(WS);
        check_quiet("rst_mid");
        send(8'h55);
        check_quiet("rst_junk");

        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            d = $urandom;
            if (a == 8'hFF) d[5:0] = 6'($urandom_range(0, 12));
            frame(a, d, $urandom_range(0, 4) == 0, 1'b1,
                  $urandom_range(0, 3) == 0);
        end
        tick();
        check_quiet("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
